// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin share of the 1-bit frame-buffer write port between CPU and accelerator, with screen clear
//
// Purpose
//   Port 0 (CPU) and port 1 (accelerator) compete for a single registered write stage
//   that drives the VGA frame store. A hardware sequencer can take over the stage and
//   fill the whole screen with one value in raster order.
//
// Ports
//   HCLK, HRESET                   clock, asynchronous active-high reset
//   req{0,1}_valid/x/y/pixel       write requests (hold stable until ready)
//   req{0,1}_ready                 request accepted this cycle (combinational)
//   clear_start, clear_value       one-cycle clear pulse and fill value
//   clear_busy                     clear sequence in progress
//   fb_we/x/y/pixel, grant_id      registered write towards the frame buffer
//   fb_ready                       frame buffer accepts the write held on fb_*
module fb_write_arbiter #(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic           HCLK,
    input  logic           HRESET,
    input  logic           req0_valid,
    input  logic [X_W-1:0] req0_x,
    input  logic [Y_W-1:0] req0_y,
    input  logic           req0_pixel,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [X_W-1:0] req1_x,
    input  logic [Y_W-1:0] req1_y,
    input  logic           req1_pixel,
    output logic           req1_ready,
    input  logic           clear_start,
    input  logic           clear_value,
    output logic           clear_busy,
    output logic           fb_we,
    output logic [X_W-1:0] fb_x,
    output logic [Y_W-1:0] fb_y,
    output logic           fb_pixel,
    input  logic           fb_ready,
    output logic           grant_id
);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
    typedef enum logic [1:0] {IDLE, CLR_DRAIN, CLR_RUN} state_t;
    state_t         r_state;
    logic           r_last;
    logic           r_busy;
    logic           r_val;
    logic           r_we;
    logic           r_pix;
    logic           r_gid;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic           w_can_load;
    logic           w_clr_go;
    logic           w_arb;
    logic           w_sel1;
    logic           w_grant;
    logic           w_in_range;
    logic           w_clr_last;
    logic [X_W-1:0] w_gx;
    logic [Y_W-1:0] w_gy;
    logic           w_gpix;
    assign w_can_load = !r_we || fb_ready;
    assign w_clr_go   = r_state == IDLE && !r_busy && clear_start;
    // Requests are stalled for the whole clear, including the wait for its final write.
    assign w_arb      = r_state == IDLE && !r_busy && !clear_start && w_can_load && !HRESET;
    // r_last holds the last-granted port; on contention the other port wins.
    assign w_sel1     = req1_valid && (!req0_valid || !r_last);
    assign req0_ready = w_arb && req0_valid && !w_sel1;
    assign req1_ready = w_arb && w_sel1;
    assign w_grant    = req0_ready || req1_ready;
    assign w_gx       = w_sel1 ? req1_x : req0_x;
    assign w_gy       = w_sel1 ? req1_y : req0_y;
    assign w_gpix     = w_sel1 ? req1_pixel : req0_pixel;
    assign w_in_range = w_gx <= X_LAST && w_gy <= Y_LAST;
    assign w_clr_last = r_cx == X_LAST && r_cy == Y_LAST;
    assign clear_busy = r_busy;
    assign fb_we      = r_we;
    assign fb_x       = r_x;
    assign fb_y       = r_y;
    assign fb_pixel   = r_pix;
    assign grant_id   = r_gid;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
            r_val   <= 1'b0;
            r_we    <= 1'b0;
            r_pix   <= 1'b0;
            r_gid   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            // A held write retires on fb_ready unless something reloads the stage below.
            if (w_can_load) r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clr_go) begin
                        r_state <= CLR_DRAIN;
                        r_busy  <= 1'b1;
                        r_val   <= clear_value;
                    end else if (w_grant) begin
                        r_last <= w_sel1;
                        if (w_in_range) begin
                            r_we  <= 1'b1;
                            r_x   <= w_gx;
                            r_y   <= w_gy;
                            r_pix <= w_gpix;
                            r_gid <= w_sel1;
                        end
                    end else if (r_busy && r_we && fb_ready) begin
                        r_busy <= 1'b0;
                    end
                end
                CLR_DRAIN: if (w_can_load) r_state <= CLR_RUN;
                CLR_RUN: begin
                    if (w_can_load) begin
                        r_we  <= 1'b1;
                        r_x   <= r_cx;
                        r_y   <= r_cy;
                        r_pix <= r_val;
                        r_gid <= 1'b0;
                        if (w_clr_last) begin
                            r_state <= IDLE;
                            r_cx    <= '0;
                            r_cy    <= '0;
                        end else if (r_cx == X_LAST) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 1'b1;
                        end else begin
                            r_cx <= r_cx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
